// File: rtl/fnd_pkg.sv
// Shared definitions for the FND display slice: segment font constants,
// conversion FSM state encoding, digit count and the largest displayable value.
package fnd_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int MAX_VALUE  = 9999;

  // Segments are active-low, [7]=dp (always off), [6:0]=g..a
  localparam logic [7:0] FONT_0     = 8'hC0;
  localparam logic [7:0] FONT_1     = 8'hF9;
  localparam logic [7:0] FONT_2     = 8'hA4;
  localparam logic [7:0] FONT_3     = 8'hB0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hF8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } fnd_state_t;

  function automatic logic [7:0] font_of(input logic [3:0] nib);
    logic [7:0] f;
    case (nib)
      4'd0:    f = FONT_0;
      4'd1:    f = FONT_1;
      4'd2:    f = FONT_2;
      4'd3:    f = FONT_3;
      4'd4:    f = FONT_4;
      4'd5:    f = FONT_5;
      4'd6:    f = FONT_6;
      4'd7:    f = FONT_7;
      4'd8:    f = FONT_8;
      4'd9:    f = FONT_9;
      default: f = FONT_BLANK;
    endcase
    return f;
  endfunction

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift
  function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Multi-cycle binary to BCD converter (double-dabble), one iteration per clock.
// Ports:
//   i_clk, i_reset_n : clock, async active-low reset
//   i_value          : binary input, clamped to MAX_VALUE on capture
//   i_load           : start strobe, honoured only in IDLE
//   o_busy           : high from the load edge until the commit edge
//   o_valid          : high during the COMMIT cycle, o_bcd holds the result then
//   o_bcd            : 4-digit BCD scratch register
module bin2bcd_seq
  import fnd_pkg::*;
#(
  parameter int VALUE_W = 14
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [VALUE_W-1:0] i_value,
  input  logic               i_load,
  output logic               o_busy,
  output logic               o_valid,
  output logic [15:0]        o_bcd
);

  localparam int ITER_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
  localparam logic [VALUE_W-1:0] MAX_V = VALUE_W'(MAX_VALUE);

  fnd_state_t         state_q;
  logic [VALUE_W-1:0] bin_q;
  logic [15:0]        bcd_q;
  logic [ITER_W-1:0]  iter_q;
  logic               busy_q;
  logic               valid_q;

  logic [VALUE_W-1:0] value_clamped;
  logic [15:0]        bcd_adj;

  assign value_clamped = (i_value > MAX_V) ? MAX_V : i_value;
  assign bcd_adj       = bcd_adjust(bcd_q);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (i_load) begin
            bin_q   <= value_clamped;
            bcd_q   <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          iter_q         <= iter_q + 1'b1;
          if (iter_q == ITER_W'(VALUE_W - 1)) begin
            // valid is raised a cycle early so it coincides with COMMIT
            valid_q <= 1'b1;
            state_q <= COMMIT;
          end
        end
        COMMIT: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_bcd   = bcd_q;

endmodule

// File: rtl/fnd_scan_ctrl.sv
// 4-digit common-anode FND driver: converts a binary value to BCD and
// time-multiplexes the digits with a prescaled scan counter.
// Ports:
//   i_clk, i_reset_n : clock, async active-low reset
//   i_value, i_load  : value to show and its capture strobe
//   i_en             : 0 blanks all digits, logic keeps running
//   o_busy           : conversion in progress
//   o_digitSelect    : current scan position, 0 = ones digit
//   o_digit          : one-hot active-low digit enables (registered)
//   o_fndFont        : active-low segments (registered)
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1_000,
  parameter int VALUE_W  = 14,
  parameter int BLANK_LZ = 1
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [VALUE_W-1:0] i_value,
  input  logic               i_load,
  input  logic               i_en,
  output logic               o_busy,
  output logic [1:0]         o_digitSelect,
  output logic [3:0]         o_digit,
  output logic [7:0]         o_fndFont
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_TERM = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [1:0]       sel_q;
  logic [15:0]      disp_q;
  logic [3:0]       digit_q, digit_d;
  logic [7:0]       font_q, font_d;

  logic             tick;
  logic             conv_valid;
  logic [15:0]      conv_bcd;
  logic [3:0]       nib;
  logic             upper_zero;

  bin2bcd_seq #(
    .VALUE_W(VALUE_W)
  ) u_bin2bcd (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_value  (i_value),
    .i_load   (i_load),
    .o_busy   (o_busy),
    .o_valid  (conv_valid),
    .o_bcd    (conv_bcd)
  );

  assign tick  = (pre_q == PRE_TERM);
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  // upper_zero: this digit and every higher digit are zero
  always_comb begin
    nib        = '0;
    upper_zero = 1'b0;
    case (sel_q)
      2'd0: begin nib = disp_q[3:0];   upper_zero = 1'b0; end
      2'd1: begin nib = disp_q[7:4];   upper_zero = (disp_q[15:4] == '0); end
      2'd2: begin nib = disp_q[11:8];  upper_zero = (disp_q[15:8] == '0); end
      2'd3: begin nib = disp_q[15:12]; upper_zero = (disp_q[15:12] == '0); end
      default: ;
    endcase
  end

  always_comb begin
    digit_d = '1;
    font_d  = FONT_BLANK;
    if (i_en) begin
      digit_d = ~(4'b0001 << sel_q);
      if ((BLANK_LZ != 0) && upper_zero) font_d = FONT_BLANK;
      else                               font_d = font_of(nib);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pre_q   <= '0;
      sel_q   <= '0;
      disp_q  <= '0;
      digit_q <= '1;
      font_q  <= '1;
    end else begin
      pre_q   <= pre_d;
      if (tick)       sel_q  <= sel_q + 1'b1;
      if (conv_valid) disp_q <= conv_bcd;
      digit_q <= digit_d;
      font_q  <= font_d;
    end
  end

  assign o_digitSelect = sel_q;
  assign o_digit       = digit_q;
  assign o_fndFont     = font_q;

endmodule
